// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the runtime-configurable UART: FSM state encodings,
// parity-mode codes, oversampling constants and small config helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Codes 0 and 3 both mean "no parity bit on the line".
  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_EVEN     = 2'd1;
  localparam logic [1:0] PAR_ODD      = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  // Keeps only the bits that belong to a frame of the configured length.
  function automatic logic [7:0] dataMask(input logic [1:0] dataBits);
    logic [7:0] mask;
    case (dataBits)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Index of the last data bit: 4 for 5-bit frames up to 7 for 8-bit frames.
  function automatic logic [2:0] lastBit(input logic [1:0] dataBits);
    return 3'd4 + {1'b0, dataBits};
  endfunction

  function automatic logic hasParity(input logic [1:0] parityMode);
    return (parityMode == PAR_EVEN) || (parityMode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_tick_gen
// Free-running oversampling tick generator shared by the RX and TX engines.
// Ports:
//   i_clk     - master clock
//   i_rst     - synchronous active-high reset, clears the counter
//   i_divisor - tick period is i_divisor+1 clocks
//   o_tick    - one-clock pulse when the counter reaches i_divisor
// ---------------------------------------------------------------------------
module uart_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_count;

  // Count 0..divisor and wrap. Wrapping on ">=" rather than "==" means a
  // divisor lowered at runtime below the current count recovers at once
  // instead of running the counter all the way round.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (r_count >= i_divisor) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == i_divisor);

endmodule

// File: rtl/uart_cfg.sv
// ---------------------------------------------------------------------------
// uart_cfg
// Runtime-configurable UART, 16x oversampling, 5-8 data bits, none/even/odd
// parity, 1 or 2 transmitted stop bits, majority-vote receiver with
// parity/framing/break detection and a valid/ready transmit handshake.
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_rx / o_tx               - serial pins (rx asynchronous, tx idles high)
//   i_divisor                 - tick period = i_divisor+1 clocks
//   i_data_bits               - 0=5, 1=6, 2=7, 3=8 data bits
//   i_parity_mode             - 0=none, 1=even, 2=odd, 3=none
//   i_two_stop                - transmit two stop bits
//   i_tx_valid/o_tx_ready     - transmit handshake, i_tx_data byte to send
//   o_rx_valid                - one-clock pulse per received frame
//   o_rx_data                 - received data, zero-extended
//   o_rx_parity_err/o_rx_frame_err/o_rx_break - status qualifying o_rx_valid
//   o_is_receiving/o_is_transmitting          - FSM activity indicators
// ---------------------------------------------------------------------------
module uart_cfg
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic [1:0]           i_data_bits,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [7:0]           i_tx_data,
  output logic                 o_rx_valid,
  output logic [7:0]           o_rx_data,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_break,
  output logic                 o_is_receiving,
  output logic                 o_is_transmitting
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_LO   = TICK_W'(SAMPLE_LO);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SAMPLE_MID);
  localparam logic [TICK_W-1:0] TICK_HI   = TICK_W'(SAMPLE_HI);

  logic w_tick;

  uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tickGen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_divisor (i_divisor),
    .o_tick    (w_tick)
  );

  // ------------------------------------------------------------------ TX --
  tx_state_t         r_txState, w_txNext;
  logic [TICK_W-1:0] r_txTick;
  logic [2:0]        r_txBitCnt, r_txLastBit;
  logic [7:0]        r_txShift;
  logic              r_txParBit, r_txHasPar, r_txTwoStop, r_txStopCnt;
  logic [7:0]        w_txMasked;
  logic              w_txAccept, w_txBitEnd;

  assign o_tx_ready = (r_txState == TX_IDLE) && !i_rst;
  assign w_txAccept = i_tx_valid && o_tx_ready;
  assign w_txBitEnd = w_tick && (r_txTick == TICK_LAST);
  assign w_txMasked = i_tx_data & dataMask(i_data_bits);

  // TX state register; reset aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txState <= TX_IDLE;
    end else begin
      r_txState <= w_txNext;
    end
  end

  // TX next state: every bit lasts 16 ticks; the stop state runs twice when
  // two stop bits were latched at accept.
  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE:   if (w_txAccept) w_txNext = TX_START;
      TX_START:  if (w_txBitEnd) w_txNext = TX_DATA;
      TX_DATA:   if (w_txBitEnd && (r_txBitCnt == r_txLastBit))
                   w_txNext = r_txHasPar ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_txBitEnd) w_txNext = TX_STOP;
      TX_STOP:   if (w_txBitEnd && (!r_txTwoStop || r_txStopCnt))
                   w_txNext = TX_IDLE;
      default:   w_txNext = TX_IDLE;
    endcase
  end

  // TX datapath: config and data are captured at accept so later changes on
  // the inputs cannot disturb the frame. The tick count restarts at accept,
  // which makes the first start-bit tick possibly partial.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txTick    <= '0;
      r_txBitCnt  <= '0;
      r_txLastBit <= '0;
      r_txShift   <= '0;
      r_txParBit  <= 1'b0;
      r_txHasPar  <= 1'b0;
      r_txTwoStop <= 1'b0;
      r_txStopCnt <= 1'b0;
    end else if (w_txAccept) begin
      r_txTick    <= '0;
      r_txBitCnt  <= '0;
      r_txLastBit <= lastBit(i_data_bits);
      r_txShift   <= w_txMasked;
      r_txParBit  <= (^w_txMasked) ^ (i_parity_mode == PAR_ODD);
      r_txHasPar  <= hasParity(i_parity_mode);
      r_txTwoStop <= i_two_stop;
      r_txStopCnt <= 1'b0;
    end else if (w_tick && (r_txState != TX_IDLE)) begin
      r_txTick <= r_txTick + 1'b1;
      if (r_txTick == TICK_LAST) begin
        if (r_txState == TX_DATA) begin
          r_txBitCnt <= r_txBitCnt + 1'b1;
          r_txShift  <= r_txShift >> 1;
        end
        if (r_txState == TX_STOP) begin
          r_txStopCnt <= 1'b1;
        end
      end
    end
  end

  // TX outputs: line level decoded from state, high whenever idle or in reset.
  always_comb begin
    o_tx              = 1'b1;
    o_is_transmitting = (r_txState != TX_IDLE);
    case (r_txState)
      TX_START:  o_tx = 1'b0;
      TX_DATA:   o_tx = r_txShift[0];
      TX_PARITY: o_tx = r_txParBit;
      default:   o_tx = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------ RX --
  rx_state_t         r_rxState, w_rxNext;
  logic [1:0]        r_rxSync;
  logic [TICK_W-1:0] r_rxTick;
  logic [2:0]        r_rxBitCnt, r_rxLastBit;
  logic [7:0]        r_rxShift;
  logic              r_rxS7, r_rxS8, r_rxParBit, r_rxHasPar, r_rxOdd;
  logic              w_rxIn, w_rxVote, w_rxDecide, w_rxBitEnd, w_rxDone;
  logic              w_rxParErr;

  assign w_rxIn     = r_rxSync[1];
  assign w_rxVote   = (r_rxS7 & r_rxS8) | (r_rxS7 & w_rxIn) | (r_rxS8 & w_rxIn);
  assign w_rxDecide = w_tick && (r_rxTick == TICK_HI);
  assign w_rxBitEnd = w_tick && (r_rxTick == TICK_LAST);
  assign w_rxParErr = r_rxHasPar && (r_rxParBit != ((^r_rxShift) ^ r_rxOdd));

  // Two-flop synchronizer for the asynchronous serial input; resets to the
  // idle line level so reset release never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rxSync <= 2'b11;
    end else begin
      r_rxSync <= {r_rxSync[0], i_rx};
    end
  end

  // RX state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rxState <= RX_IDLE;
    end else begin
      r_rxState <= w_rxNext;
    end
  end

  // RX next state: bit value is decided at tick 9, bits advance at tick 15.
  // A high start vote is a false start. The stop decision ends the frame
  // right away so the back half of the stop bit can already see a new start.
  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE:    if (!w_rxIn) w_rxNext = RX_START;
      RX_START:   if (w_rxDecide && w_rxVote) w_rxNext = RX_IDLE;
                  else if (w_rxBitEnd) w_rxNext = RX_DATA;
      RX_DATA:    if (w_rxBitEnd && (r_rxBitCnt == r_rxLastBit))
                    w_rxNext = r_rxHasPar ? RX_PARITY : RX_STOP;
      RX_PARITY:  if (w_rxBitEnd) w_rxNext = RX_STOP;
      RX_STOP:    if (w_rxDecide) w_rxNext = w_rxVote ? RX_IDLE : RX_RECOVER;
      RX_RECOVER: if (w_rxIn) w_rxNext = RX_IDLE;
      default:    w_rxNext = RX_IDLE;
    endcase
  end

  // RX datapath: config is latched on start detection. Samples at ticks 7
  // and 8 are stored and combined with the live tick-9 sample for the vote.
  // Data bits are written by index into a cleared register, so shorter
  // frames come out zero-extended.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rxTick    <= '0;
      r_rxBitCnt  <= '0;
      r_rxLastBit <= '0;
      r_rxShift   <= '0;
      r_rxS7      <= 1'b1;
      r_rxS8      <= 1'b1;
      r_rxParBit  <= 1'b0;
      r_rxHasPar  <= 1'b0;
      r_rxOdd     <= 1'b0;
    end else if ((r_rxState == RX_IDLE) && !w_rxIn) begin
      r_rxTick    <= '0;
      r_rxBitCnt  <= '0;
      r_rxLastBit <= lastBit(i_data_bits);
      r_rxShift   <= '0;
      r_rxParBit  <= 1'b0;
      r_rxHasPar  <= hasParity(i_parity_mode);
      r_rxOdd     <= (i_parity_mode == PAR_ODD);
    end else if (w_tick && (r_rxState != RX_IDLE)) begin
      r_rxTick <= r_rxTick + 1'b1;
      if (r_rxTick == TICK_LO) begin
        r_rxS7 <= w_rxIn;
      end
      if (r_rxTick == TICK_MID) begin
        r_rxS8 <= w_rxIn;
      end
      if (r_rxTick == TICK_HI) begin
        if (r_rxState == RX_DATA) begin
          r_rxShift[r_rxBitCnt] <= w_rxVote;
        end
        if (r_rxState == RX_PARITY) begin
          r_rxParBit <= w_rxVote;
        end
      end
      if ((r_rxTick == TICK_LAST) && (r_rxState == RX_DATA)) begin
        r_rxBitCnt <= r_rxBitCnt + 1'b1;
      end
    end
  end

  // RX outputs: completion strobe and activity flag.
  always_comb begin
    w_rxDone       = (r_rxState == RX_STOP) && w_rxDecide;
    o_is_receiving = (r_rxState != RX_IDLE);
  end

  // Received data and status are registered on the stop decision and held
  // until the next frame. Break means a framing error on an all-zero frame
  // whose parity bit, if any, was also low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_valid      <= 1'b0;
      o_rx_data       <= '0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      o_rx_break      <= 1'b0;
    end else begin
      o_rx_valid <= w_rxDone;
      if (w_rxDone) begin
        o_rx_data       <= r_rxShift;
        o_rx_parity_err <= w_rxParErr;
        o_rx_frame_err  <= !w_rxVote;
        o_rx_break      <= !w_rxVote && (r_rxShift == 8'h00) &&
                           (!r_rxHasPar || !r_rxParBit);
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_cfg
// Directed bench for uart_cfg with divisor=3 (4 clocks per tick, 64 clocks
// per bit). TX is observed mid-bit; RX is fed either by looping tx back or
// by bit-banging frames onto the rx pin.
// ---------------------------------------------------------------------------
module tb_uart_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx, rxDrive, loopback;
  logic        tx;
  logic [15:0] divisor;
  logic [1:0]  dataBits, parityMode;
  logic        twoStop;
  logic        txValid, txReady;
  logic [7:0]  txData;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxParErr, rxFrameErr, rxBreak;
  logic        isRx, isTx;

  int          passCount = 0;
  int          failCount = 0;
  int          checkCount = 0;
  int          rxCount = 0;
  logic [7:0]  capData;
  logic        capPar, capFrame, capBreak;
  logic [19:0] txBits;
  int          frameLen, extra, base;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  assign rx = loopback ? tx : rxDrive;

  uart_cfg #(.DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rx              (rx),
    .o_tx              (tx),
    .i_divisor         (divisor),
    .i_data_bits       (dataBits),
    .i_parity_mode     (parityMode),
    .i_two_stop        (twoStop),
    .i_tx_valid        (txValid),
    .o_tx_ready        (txReady),
    .i_tx_data         (txData),
    .o_rx_valid        (rxValid),
    .o_rx_data         (rxData),
    .o_rx_parity_err   (rxParErr),
    .o_rx_frame_err    (rxFrameErr),
    .o_rx_break        (rxBreak),
    .o_is_receiving    (isRx),
    .o_is_transmitting (isTx)
  );

  // Capture every received frame so stimulus can keep running while the
  // receiver finishes; sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      rxCount  = rxCount + 1;
      capData  = rxData;
      capPar   = rxParErr;
      capFrame = rxFrameErr;
      capBreak = rxBreak;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] bits, input logic [1:0] par,
                               input logic stop2);
    dataBits   = bits;
    parityMode = par;
    twoStop    = stop2;
  endtask

  // Returns on the falling edge right after the accepting clock edge.
  task automatic startTx(input logic [7:0] data);
    int n = 0;
    while (txReady !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_ready before send", 32'(txReady), 32'd1);
    txData  = data;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // Samples tx in the middle of each bit, starting from the post-accept
  // falling edge; optionally drops tx_valid when bit dropAt is sampled.
  task automatic sampleTxFrame(input int nBits, input int dropAt,
                               output logic [19:0] bits);
    bits = '1;
    for (int k = 0; k < nBits; k++) begin
      repeat ((k == 0) ? 32 : 64) @(negedge clk);
      bits[k] = tx;
      if (k == dropAt) txValid = 1'b0;
    end
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (txReady !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_ready return", 32'(txReady), 32'd1);
  endtask

  task automatic waitRx(input int target);
    int n = 0;
    while (rxCount < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_valid count", 32'(rxCount), 32'(target));
  endtask

  // Bit-bangs a frame (bit 0 first, 64 clocks per bit); a 4-clock high
  // spike can be placed over the tick-8 sample of bit spikeBit.
  task automatic driveFrame(input logic [11:0] bits, input int n, input int spikeBit);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 64; c++) begin
        rxDrive = (b == spikeBit && c >= 33 && c <= 36) ? 1'b1 : bits[b];
        @(negedge clk);
      end
    end
    rxDrive = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    rxDrive  = 1'b1;
    loopback = 1'b0;
    divisor  = 16'd3;
    txValid  = 1'b0;
    txData   = 8'h00;
    applyStimulus(2'd3, 2'd0, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset tx_ready", 32'(txReady), 32'd0);
    checkOutput("reset rx_valid", 32'(rxValid), 32'd0);
    checkOutput("reset rx_data", 32'(rxData), 32'd0);
    checkOutput("reset flags", 32'({rxParErr, rxFrameErr, rxBreak}), 32'd0);
    checkOutput("reset busy", 32'({isRx, isTx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 8N1 loopback 0xA5");
    loopback = 1'b1;
    base = rxCount;
    startTx(8'hA5);
    sampleTxFrame(10, -1, txBits);
    checkOutput("8N1 tx waveform", 32'(txBits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
    waitReady(extra);
    frameLen = 32 + 9 * 64 + extra;
    checkOutput("8N1 frame length", 32'(frameLen >= 635 && frameLen <= 641), 32'd1);
    waitRx(base + 1);
    checkOutput("8N1 rx_data", 32'(capData), 32'hA5);
    checkOutput("8N1 rx flags", 32'({capPar, capFrame, capBreak}), 32'd0);

    $display("[TB] 7E2 loopback 0xD3 (top bit ignored)");
    applyStimulus(2'd2, 2'd1, 1'b1);
    base = rxCount;
    startTx(8'hD3);
    sampleTxFrame(11, -1, txBits);
    checkOutput("7E2 tx waveform", 32'(txBits[10:0]), 32'({2'b11, 1'b0, 7'h53, 1'b0}));
    waitReady(extra);
    frameLen = 32 + 10 * 64 + extra;
    checkOutput("7E2 frame length", 32'(frameLen >= 699 && frameLen <= 705), 32'd1);
    waitRx(base + 1);
    checkOutput("7E2 rx_data", 32'(capData), 32'h53);
    checkOutput("7E2 rx flags", 32'({capPar, capFrame, capBreak}), 32'd0);
    loopback = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] 8O1 good and flipped parity");
    applyStimulus(2'd3, 2'd2, 1'b0);
    base = rxCount;
    driveFrame({1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1);
    waitRx(base + 1);
    checkOutput("8O1 good rx_data", 32'(capData), 32'h3C);
    checkOutput("8O1 good flags", 32'({capPar, capFrame, capBreak}), 32'd0);
    repeat (20) @(negedge clk);
    driveFrame({1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
    waitRx(base + 2);
    checkOutput("8O1 bad rx_data", 32'(capData), 32'h3C);
    checkOutput("8O1 bad flags", 32'({capPar, capFrame, capBreak}), 32'b100);
    repeat (20) @(negedge clk);

    $display("[TB] break: rx low for 20 bit periods");
    applyStimulus(2'd3, 2'd0, 1'b0);
    base = rxCount;
    rxDrive = 1'b0;
    repeat (1280) @(negedge clk);
    checkOutput("break rx_valid count", 32'(rxCount - base), 32'd1);
    checkOutput("break rx_data", 32'(capData), 32'h00);
    checkOutput("break flags", 32'({capPar, capFrame, capBreak}), 32'b011);
    checkOutput("break recover busy", 32'(isRx), 32'd1);
    rxDrive = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("break no extra valid", 32'(rxCount - base), 32'd1);
    checkOutput("break back idle", 32'(isRx), 32'd0);
    driveFrame({2'b0, 1'b1, 8'h5A, 1'b0}, 10, -1);
    waitRx(base + 2);
    checkOutput("after break rx_data", 32'(capData), 32'h5A);
    checkOutput("after break flags", 32'({capPar, capFrame, capBreak}), 32'd0);
    repeat (20) @(negedge clk);

    $display("[TB] glitch and spike");
    base = rxCount;
    rxDrive = 1'b0;
    repeat (16) @(negedge clk);
    rxDrive = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("glitch start seen", 32'(isRx), 32'd1);
    repeat (100) @(negedge clk);
    checkOutput("glitch back idle", 32'(isRx), 32'd0);
    checkOutput("glitch no valid", 32'(rxCount - base), 32'd0);
    driveFrame({2'b0, 1'b1, 8'h00, 1'b0}, 10, 4);
    waitRx(base + 1);
    checkOutput("spike rx_data", 32'(capData), 32'h00);
    checkOutput("spike flags", 32'({capPar, capFrame, capBreak}), 32'd0);
    repeat (20) @(negedge clk);

    $display("[TB] reset mid-frame and back-to-back bytes");
    startTx(8'h00);
    repeat (200) @(negedge clk);
    checkOutput("tx low mid data", 32'(tx), 32'd0);
    txData  = 8'h00;
    txValid = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    checkOutput("tx high after rst", 32'(tx), 32'd1);
    checkOutput("tx_ready low in rst", 32'(txReady), 32'd0);
    checkOutput("not transmitting in rst", 32'(isTx), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("tx_ready after release", 32'(txReady), 32'd1);
    @(negedge clk);
    txData = 8'hFF;
    sampleTxFrame(20, 10, txBits);
    checkOutput("back-to-back waveform", 32'(txBits),
                32'({1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}));
    waitReady(extra);
    repeat (10) @(negedge clk);
    checkOutput("no third frame", 32'(isTx), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
# uart_cfg

Runtime-configurable UART with 16x oversampling. It is the successor to the fixed 8N1 UART block. It adds:
- a runtime baud divisor;
- 5–8 data bits, none/even/odd parity, 1 or 2 stop bits;
- majority-vote sampling, parity/framing/break detection;
- a valid/ready transmit handshake.

It sits between the host-link command parser and the board serial pins.

## Interface
- DIV_WIDTH, 16, width of the baud divisor input.
- OVERSAMPLE, 16, ticks per bit; fixed, exposed for the testbench only.

- clk  in  1  master clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- divisor  in  DIV_WIDTH  tick period = divisor+1 clk cycles
- data_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8
- parity_mode  in  2  0=none, 1=even, 2=odd, 3=none
- two_stop  in  1  1 = transmit two stop bits
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  transmitter idle, accepts a byte
- tx_data  in  8  byte to send; bits above data length are ignored
- rx_valid  out  1  one-cycle pulse: frame complete
- rx_data  out  8  received data, zero-extended
- rx_parity_err  out  1  qualifies rx_valid
- rx_frame_err  out  1  stop bit sampled low; qualifies rx_valid
- rx_break  out  1  all-zero frame with low stop; qualifies rx_valid
- is_receiving  out  1  RX state machine not in IDLE
- is_transmitting  out  1  TX state machine not in IDLE

## Operation
- **Tick generator.** Free-running counter 0..divisor. It pulses `tick` when count==divisor, then wraps to 0. divisor=0 gives a tick every clk. Bit period = 16·(divisor+1) clk.
- **Config sampling.** TX latches data_bits, parity_mode and two_stop at accept. RX latches them at start detection. Changes mid-frame do not affect the frame in progress.
- **RX input.** Passes through a 2-flop synchronizer that resets to 1.

**TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.**
- Accept when tx_valid && tx_ready. tx_data is latched and tx goes 0 on the next clk.
- Each bit lasts 16 ticks. The START bit is counted from accept, so its first tick may be partial.
- DATA: LSB first, exactly N bits.
- PARITY is skipped when parity_mode is none. Even: parity bit = XOR of the data bits. Odd: its inverse.
- STOP holds tx high for 16 ticks, or 32 ticks when two_stop=1.
- tx_ready = (state==IDLE) && !rst. Back-to-back frames are allowed: a new accept can happen on the cycle tx_ready returns high.

**RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE/RECOVER.**
- IDLE: synchronized rx low → START, and the tick count clears to 0.
- Every bit takes a majority vote of samples at ticks 7, 8 and 9. The decision is made at tick 9, after which the bit counter advances at tick 15.
- START: majority 1 → back to IDLE silently (false start, no flag).
- STOP: only the first stop bit is checked; the receiver always accepts 1 stop bit. After the stop decision, rx_valid pulses for one clk:
  - rx_data is updated;
  - rx_parity_err = parity mismatch;
  - rx_frame_err = stop low;
  - rx_break = rx_frame_err && all data bits 0 && (no parity or parity bit 0).
- Next state: IDLE if stop was high, else RECOVER. RECOVER waits for synchronized rx high, then → IDLE.
- rx_data and the three flags hold until the next rx_valid.
- No backpressure and no overrun detection. The consumer must capture on rx_valid.

## Timing
- Reset values: tx=1, tx_ready=0 while rst, rx_valid=0, rx_data=0, all error flags 0, is_receiving=0, is_transmitting=0. Tick counter = 0.
- Reset mid-frame aborts both FSMs. tx is 1 on the cycle after rst is sampled high.
- TX frame length from accept: (1+N+P+S)·16 ticks ±1 tick, where P ∈ {0,1} and S ∈ {1,2}. tx_ready rises 1 clk after the final stop tick.
- RX latency: rx_valid fires 2 sync clks + ((1+N+P)·16+9) ticks after the rx falling edge, +1 clk (±1 tick phase).
- Example: 50 MHz clk, divisor=26 gives 115 741 baud (+0.47 %).

## Structure
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums;
  - parity-mode encodings;
  - OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
- Sub-module uart_tick_gen (divisor in, tick out) is shared by RX and TX.
- The RX and TX FSMs stay in uart_cfg.

## Test plan
- 8N1, divisor=3: send 0xA5 → tx waveform 0,1,0,1,0,0,1,0,1,1, each bit 64 clk. Loop tx back to rx → rx_valid with rx_data=0xA5, no flags.
- 7E2: send 0x53 → data 1100101, parity 0, two stop bits, frame 11·16 ticks. Loopback yields 0x53.
- 8O1 with the parity bit flipped on the line → rx_valid with rx_parity_err=1 and rx_data correct.
- rx held low for 20 bit periods → one rx_valid with rx_break=1, rx_frame_err=1, rx_data=0x00. No further rx_valid until rx returns high and a new start arrives.
- rx low glitch of 4 ticks → no rx_valid, is_receiving returns to 0. A 1-tick high spike at tick 8 of a data bit does not alter that bit.
- rst asserted mid-TX-data → tx=1 the next cycle, tx_ready=1 after release. tx_valid held high through the reset → new frame starts cleanly; two consecutive bytes 0x00, 0xFF are sent with no idle gap.
